// File: rtl/in_stage_pkg.sv
// Shared constants for the input filter stage: default geometry, the legal synchroniser
// depth range, and the per-cycle filter decision type.
package in_stage_pkg;

  localparam int IN_WIDTH_DEF       = 7;
  localparam int IN_SYNC_STAGES_DEF = 2;
  localparam int IN_FILT_W_DEF      = 4;

  localparam int IN_SYNC_STAGES_MIN = 2;
  localparam int IN_SYNC_STAGES_MAX = 4;

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_COUNT  = 2'd1,
    ACT_UPDATE = 2'd2
  } filt_act_e;

  function automatic bit sync_stages_legal(input int n);
    return (n >= IN_SYNC_STAGES_MIN) && (n <= IN_SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/in_filter_chan.sv
// One input channel: synchroniser, polarity inversion, glitch filter and (with
// IN_FILTER_EDGE_EN) registered rise/fall event flops.
module in_filter_chan
  import in_stage_pkg::*;
#(
  parameter int SYNC_STAGES = IN_SYNC_STAGES_DEF,
  parameter int FILT_W      = IN_FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pin,
  input  logic              inv,
  input  logic [FILT_W-1:0] filt_len,
  output logic              ivalue
`ifdef IN_FILTER_EDGE_EN
  ,
  output logic              rise,
  output logic              fall
`endif
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   ivalue_q, ivalue_d;
  logic                   cand;
  filt_act_e              act;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pin};
    // Inversion sits after the synchroniser, so a polarity change is filtered like a pin edge.
    cand     = sync_q[SYNC_STAGES-1] ^ inv;
    act      = ACT_HOLD;
    cnt_d    = '0;
    ivalue_d = ivalue_q;
    if (cand != ivalue_q) begin
      if (cnt_q >= filt_len) begin
        act      = ACT_UPDATE;
        ivalue_d = cand;
      end else begin
        act   = ACT_COUNT;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      ivalue_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      ivalue_q <= ivalue_d;
    end
  end

  assign ivalue = ivalue_q;

`ifdef IN_FILTER_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = (act == ACT_UPDATE) &&  cand;
    fall_d = (act == ACT_UPDATE) && !cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: rtl/in_filter_stage.sv
// Input pin stage: WIDTH independent synchronise/invert/glitch-filter channels.
// Optional rise/fall event outputs are built when IN_FILTER_EDGE_EN is defined.
module in_filter_stage
  import in_stage_pkg::*;
#(
  parameter int WIDTH       = IN_WIDTH_DEF,
  parameter int SYNC_STAGES = IN_SYNC_STAGES_DEF,
  parameter int FILT_W      = IN_FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  invert_polarity,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [WIDTH-1:0]  ipins,
  output logic [WIDTH-1:0]  ivalues
`ifdef IN_FILTER_EDGE_EN
  ,
  output logic [WIDTH-1:0]  rise,
  output logic [WIDTH-1:0]  fall
`endif
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync
    $error("in_filter_stage: SYNC_STAGES out of range");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    in_filter_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin      (ipins[gi]),
      .inv      (invert_polarity[gi]),
      .filt_len (filt_len),
      .ivalue   (ivalues[gi])
`ifdef IN_FILTER_EDGE_EN
      ,
      .rise     (rise[gi]),
      .fall     (fall[gi])
`endif
    );
  end

endmodule

// File: tb/tb_in_filter_stage.sv
// Randomised and directed bench for in_filter_stage against a run-length reference model.
// Checks rise/fall too when IN_FILTER_EDGE_EN is defined.
module tb_in_filter_stage;

  localparam int W  = 7;
  localparam int SS = 2;
  localparam int FW = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  invert_polarity;
  logic [FW-1:0] filt_len;
  logic [W-1:0]  ipins;
  logic [W-1:0]  ivalues;
`ifdef IN_FILTER_EDGE_EN
  logic [W-1:0]  rise;
  logic [W-1:0]  fall;
`endif

  in_filter_stage #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .invert_polarity (invert_polarity),
    .filt_len        (filt_len),
    .ipins           (ipins),
    .ivalues         (ivalues)
`ifdef IN_FILTER_EDGE_EN
    ,
    .rise            (rise),
    .fall            (fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: pin history delayed by SS edges, plus per-channel run length of differing cycles.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_out;
  int           run[W];
  logic [W-1:0] exp_rise, exp_fall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    hist.delete();
    for (int k = 0; k < SS; k++) hist.push_back('0);
    m_out    = '0;
    exp_rise = '0;
    exp_fall = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  task automatic step();
    logic [W-1:0] cand;
    exp_rise = '0;
    exp_fall = '0;
    if (rst_n) begin
      cand = hist[0] ^ invert_polarity;
      for (int i = 0; i < W; i++) begin
        if (cand[i] == m_out[i]) begin
          run[i] = 0;
        end else if (run[i] >= int'(filt_len)) begin
          m_out[i] = cand[i];
          run[i]   = 0;
          if (cand[i]) exp_rise[i] = 1'b1;
          else         exp_fall[i] = 1'b1;
        end else begin
          run[i]++;
        end
      end
      hist.push_back(ipins);
      void'(hist.pop_front());
    end
    @(posedge clk);
    #1;
    check_eq("ivalues", 32'(ivalues), 32'(m_out));
`ifdef IN_FILTER_EDGE_EN
    check_eq("rise", 32'(rise), 32'(exp_rise));
    check_eq("fall", 32'(fall), 32'(exp_fall));
    check_eq("rise_fall_excl", 32'(rise & fall), 32'd0);
`endif
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic async_reset(input int hold_cycles);
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_eq("async_rst_ivalues", 32'(ivalues), 32'd0);
`ifdef IN_FILTER_EDGE_EN
    check_eq("async_rst_edges", 32'(rise | fall), 32'd0);
`endif
    steps(hold_cycles);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    ipins           = '0;
    invert_polarity = '0;
    filt_len        = '0;
    m_reset();
    #2;
    check_eq("reset_state", 32'(ivalues), 32'd0);
    steps(2);
    rst_n = 1'b1;

    // Reset mid-count, then release with all pins high
    ipins    = 7'h7F;
    filt_len = 4'd3;
    steps(4);
    async_reset(2);
    filt_len = 4'd0;
    step(); check_eq("lat_edge1", 32'(ivalues), 32'd0);
    step(); check_eq("lat_edge2", 32'(ivalues), 32'd0);
    step(); check_eq("lat_edge3", 32'(ivalues), 32'h7F);
`ifdef IN_FILTER_EDGE_EN
    check_eq("rise_edge3", 32'(rise), 32'h7F);
    step(); check_eq("rise_edge4", 32'(rise), 32'd0);
`else
    step();
`endif

    // Filter length 3
    ipins = '0;
    steps(4);
    filt_len = 4'd3;
    ipins    = 7'h01;
    steps(5); check_eq("filt3_edge5", 32'(ivalues[0]), 32'd0);
    step();   check_eq("filt3_edge6", 32'(ivalues[0]), 32'd1);
    ipins = '0;
    steps(7);
    ipins = 7'h01;
    steps(3);
    ipins = '0;
    steps(8); check_eq("glitch_blocked", 32'(ivalues), 32'd0);
    ipins = 7'h01;
    steps(5); check_eq("post_glitch_edge5", 32'(ivalues[0]), 32'd0);
    step();   check_eq("post_glitch_edge6", 32'(ivalues[0]), 32'd1);

    // filt_len lowered from 10 to 2 while the count is at 5
    ipins    = '0;
    filt_len = 4'd0;
    steps(4);
    filt_len = 4'd10;
    ipins    = 7'h02;
    steps(7); check_eq("len10_cnt5", 32'(ivalues), 32'd0);
    filt_len = 4'd2;
    step();   check_eq("len_lowered", 32'(ivalues), 32'h02);

    // Polarity change, filtered but with no sync delay
    ipins    = '0;
    filt_len = 4'd0;
    steps(4);
    invert_polarity = 7'h55;
    step(); check_eq("pol_edge1", 32'(ivalues), 32'h55);
`ifdef IN_FILTER_EDGE_EN
    check_eq("pol_rise", 32'(rise), 32'h55);
`endif
    step();
    invert_polarity = '0;
    steps(3);

    // Independence: channel 3 glitches every cycle, channel 5 gets a clean edge
    filt_len = 4'd2;
    for (int k = 1; k <= 10; k++) begin
      ipins[5] = 1'b1;
      ipins[3] = ~ipins[3];
      step();
      check_eq("ch3_stable", 32'(ivalues[3]), 32'd0);
      if (k == 4) check_eq("ch5_edge4", 32'(ivalues[5]), 32'd0);
      if (k == 5) check_eq("ch5_edge5", 32'(ivalues[5]), 32'd1);
    end

    // Random phase
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(5) == 0) ipins[i] = ~ipins[i];
      if ($urandom_range(30) == 0) invert_polarity = W'($urandom);
      if ($urandom_range(40) == 0)
        filt_len = ($urandom_range(7) == 0) ? 4'd15 : FW'($urandom_range(5));
      if (c == 300) async_reset(1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
